bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 41 ++++
 rtl/bus_arbiter.sv | 132 +++++++++++++
 tb/tb_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Master-side request/response bundle plus shared slave-side bus of the arbiter.
// The slave modport is the arbiter's own view; master is the environment's view.
interface bus_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int XLEN      = 32
);
    localparam int GW = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0]      i_m_bus_en;
    logic [N_MASTERS-1:0]      i_m_wr_en;
    logic [N_MASTERS-1:0]      i_m_lock;
    logic [N_MASTERS*XLEN-1:0] i_m_addr;
    logic [N_MASTERS*XLEN-1:0] i_m_wr_data;
    logic [N_MASTERS*4-1:0]    i_m_byte_en;
    logic [N_MASTERS-1:0]      o_m_ack;
    logic [XLEN-1:0]           o_m_rd_data;

    logic                      o_bus_en;
    logic                      o_wr_en;
    logic [XLEN-1:0]           o_addr;
    logic [XLEN-1:0]           o_wr_data;
    logic [3:0]                o_byte_en;
    logic                      i_ack;
    logic [XLEN-1:0]           i_rd_data;

    logic [GW-1:0]             o_grant;

    modport slave (
        input  i_m_bus_en, i_m_wr_en, i_m_lock, i_m_addr, i_m_wr_data, i_m_byte_en,
        input  i_ack, i_rd_data,
        output o_m_ack, o_m_rd_data,
        output o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en, o_grant
    );

    modport master (
        output i_m_bus_en, i_m_wr_en, i_m_lock, i_m_addr, i_m_wr_data, i_m_byte_en,
        output i_ack, i_rd_data,
        input  o_m_ack, o_m_rd_data,
        input  o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en, o_grant
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between N_MASTERS masters, with
// per-master lock for atomic sequences.
//   state | meaning
//   IDLE  | no transaction; arbitrate among requesters from rr_ptr
//   BUSY  | latched request driven on the slave bus, waiting for i_ack
//   HOLD  | locked owner keeps the bus; only its requests are served
module bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int XLEN      = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    bus_arbiter_if.slave  bus
);
    localparam int GW = $clog2(N_MASTERS);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic                req_wr_q, req_wr_d;
    logic [XLEN-1:0]     req_addr_q, req_addr_d;
    logic [XLEN-1:0]     req_wdata_q, req_wdata_d;
    logic [3:0]          req_be_q, req_be_d;

    logic [GW-1:0]       sel_idx;
    logic                sel_vld;
    logic                load;
    logic [N_MASTERS-1:0] ack_vec;
    int                  cand;

    logic [XLEN-1:0]     m_addr  [N_MASTERS];
    logic [XLEN-1:0]     m_wdata [N_MASTERS];
    logic [3:0]          m_be    [N_MASTERS];

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
        assign m_addr[k]  = bus.i_m_addr[k*XLEN +: XLEN];
        assign m_wdata[k] = bus.i_m_wr_data[k*XLEN +: XLEN];
        assign m_be[k]    = bus.i_m_byte_en[k*4 +: 4];
    end

    // Walk downwards so the last hit is the requester closest after rr_ptr.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        cand    = 0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= N_MASTERS) cand = cand - N_MASTERS;
            if (bus.i_m_bus_en[GW'(cand)]) begin
                sel_idx = GW'(cand);
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        load     = 1'b0;
        ack_vec  = '0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    grant_d = sel_idx;
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.i_ack) begin
                    ack_vec[grant_q] = 1'b1;
                    rr_ptr_d = (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + GW'(1);
                    state_d  = bus.i_m_lock[grant_q] ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (bus.i_m_bus_en[grant_q]) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end else if (!bus.i_m_lock[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_wr_d    = req_wr_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        if (load) begin
            req_wr_d    = bus.i_m_wr_en[grant_d];
            req_addr_d  = m_addr[grant_d];
            req_wdata_d = m_wdata[grant_d];
            req_be_d    = m_be[grant_d];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            req_wr_q    <= req_wr_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
        end
    end

    assign bus.o_bus_en    = (state_q == BUSY);
    assign bus.o_wr_en     = req_wr_q;
    assign bus.o_addr      = req_addr_q;
    assign bus.o_wr_data   = req_wdata_q;
    assign bus.o_byte_en   = req_be_q;
    assign bus.o_grant     = grant_q;
    assign bus.o_m_ack     = ack_vec;
    assign bus.o_m_rd_data = bus.i_rd_data;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (2 masters, 32-bit): expected transactions are
// queued when a request is driven and popped when the matching ack appears.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.N_MASTERS(2), .XLEN(32)) bif ();

    bus_arbiter #(.N_MASTERS(2), .XLEN(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bif)
    );

    typedef struct {
        int          m;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int m, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be, input logic lk);
        if (m == 0) begin
            bif.i_m_bus_en[0] = 1'b1; bif.i_m_wr_en[0] = wr; bif.i_m_lock[0] = lk;
            bif.i_m_addr[31:0] = a; bif.i_m_wr_data[31:0] = d; bif.i_m_byte_en[3:0] = be;
        end else begin
            bif.i_m_bus_en[1] = 1'b1; bif.i_m_wr_en[1] = wr; bif.i_m_lock[1] = lk;
            bif.i_m_addr[63:32] = a; bif.i_m_wr_data[63:32] = d; bif.i_m_byte_en[7:4] = be;
        end
        sb.push_back('{m: m, wr: wr, addr: a, wdata: d, be: be});
    endtask

    task automatic drop_req(input int m);
        if (m == 0) bif.i_m_bus_en[0] = 1'b0;
        else        bif.i_m_bus_en[1] = 1'b0;
    endtask

    task automatic check_req(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb[0];
            chk({tag, "_bus_en"}, 64'(bif.o_bus_en), 64'd1);
            chk({tag, "_grant"},  64'(bif.o_grant), 64'(e.m));
            chk({tag, "_wr_en"},  64'(bif.o_wr_en), 64'(e.wr));
            chk({tag, "_addr"},   64'(bif.o_addr), 64'(e.addr));
            chk({tag, "_wdata"},  64'(bif.o_wr_data), 64'(e.wdata));
            chk({tag, "_be"},     64'(bif.o_byte_en), 64'(e.be));
        end
    endtask

    task automatic do_ack(input string tag, input logic [31:0] rd);
        exp_t e;
        logic [63:0] one;
        one = 64'd1;
        bif.i_ack = 1'b1;
        bif.i_rd_data = rd;
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ack"},     64'(bif.o_m_ack), one << e.m);
            chk({tag, "_rd_data"}, 64'(bif.o_m_rd_data), 64'(rd));
        end
    endtask

    task automatic finish_ack(input string tag);
        step();
        chk({tag, "_ack_one_cycle"}, 64'(bif.o_m_ack), 64'd0);
        bif.i_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, nack;
        exp_t e;
        bif.i_m_bus_en = '0; bif.i_m_wr_en = '0; bif.i_m_lock = '0;
        bif.i_m_addr = '0; bif.i_m_wr_data = '0; bif.i_m_byte_en = '0;
        bif.i_ack = 1'b0; bif.i_rd_data = '0;

        // Reset state, with master 1's read already pending
        step();
        drive_req(1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1'b0);
        step();
        chk("rst_bus_en", 64'(bif.o_bus_en), 64'd0);
        chk("rst_wr_en",  64'(bif.o_wr_en), 64'd0);
        chk("rst_addr",   64'(bif.o_addr), 64'd0);
        chk("rst_wdata",  64'(bif.o_wr_data), 64'd0);
        chk("rst_be",     64'(bif.o_byte_en), 64'd0);
        chk("rst_ack",    64'(bif.o_m_ack), 64'd0);
        chk("rst_grant",  64'(bif.o_grant), 64'd0);

        // Single read: granted on the first edge after release, acked 2 cycles in
        rst = 1'b1;
        step();
        check_req("rd_t1");
        drop_req(1);
        step();
        check_req("rd_wait");
        do_ack("rd", 32'hDEAD_BEEF);
        finish_ack("rd");
        chk("rd_idle_bus_en", 64'(bif.o_bus_en), 64'd0);
        step();
        chk("rd_no_regrant", 64'(bif.o_bus_en), 64'd0);

        // Fairness: both request, slave acks every BUSY cycle
        drive_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0);
        drive_req(1, 1'b0, 32'h0000_0014, 32'h0, 4'hF, 1'b0);
        drive_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0);
        drive_req(1, 1'b0, 32'h0000_0014, 32'h0, 4'hF, 1'b0);
        bif.i_ack = 1'b1;
        bif.i_rd_data = 32'h1111_2222;
        a0 = 0; a1 = 0; nack = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bif.o_m_ack != 2'b00) begin
                nack++;
                a0 += int'(bif.o_m_ack[0]);
                a1 += int'(bif.o_m_ack[1]);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("fair_grant", 64'(bif.o_grant), 64'(e.m));
                    chk("fair_addr",  64'(bif.o_addr), 64'(e.addr));
                end
            end
        end
        chk("fair_total_acks", 64'(nack), 64'd4);
        chk("fair_m0_acks", 64'(a0), 64'd2);
        chk("fair_m1_acks", 64'(a1), 64'd2);
        drop_req(0);
        drop_req(1);
        bif.i_ack = 1'b0;
        step();

        // Request stability: master 0 write, inputs change while BUSY
        drive_req(0, 1'b1, 32'h0000_0020, 32'h55AA_55AA, 4'h3, 1'b0);
        step();
        check_req("stab_t1");
        bif.i_m_addr[31:0] = 32'h0000_0040;
        bif.i_m_wr_data[31:0] = 32'h1234_5678;
        bif.i_m_byte_en[3:0] = 4'hF;
        drop_req(0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_req("stab_hold");
        end
        do_ack("stab", 32'h0);
        finish_ack("stab");

        // Stray ack in IDLE
        bif.i_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stray_ack", 64'(bif.o_m_ack), 64'd0);
            step();
            chk("stray_bus_en", 64'(bif.o_bus_en), 64'd0);
        end
        bif.i_ack = 1'b0;

        // Lock: three back-to-back transactions for master 0 while master 1 waits
        drive_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b1);
        step();
        check_req("lk1");
        bif.i_m_bus_en[1] = 1'b1; bif.i_m_wr_en[1] = 1'b0;
        bif.i_m_addr[63:32] = 32'h0000_0200; bif.i_m_wr_data[63:32] = 32'h0;
        bif.i_m_byte_en[7:4] = 4'hF;
        do_ack("lk1", 32'h0000_00A1);
        drive_req(0, 1'b1, 32'h0000_0104, 32'h0000_CAFE, 4'hF, 1'b1);
        finish_ack("lk1");
        chk("lk_hold1_bus_en", 64'(bif.o_bus_en), 64'd0);
        step();
        check_req("lk2");
        do_ack("lk2", 32'h0000_00A2);
        drive_req(0, 1'b0, 32'h0000_0108, 32'h0, 4'hF, 1'b1);
        finish_ack("lk2");
        step();
        check_req("lk3");
        do_ack("lk3", 32'h0000_00A3);
        drop_req(0);
        finish_ack("lk3");
        step();
        chk("lk_hold_bus_en", 64'(bif.o_bus_en), 64'd0);
        chk("lk_hold_grant",  64'(bif.o_grant), 64'd0);
        bif.i_m_lock[0] = 1'b0;
        sb.push_back('{m: 1, wr: 1'b0, addr: 32'h0000_0200, wdata: 32'h0, be: 4'hF});
        step();
        chk("lk_release_idle", 64'(bif.o_bus_en), 64'd0);
        step();
        check_req("lk_m1");
        do_ack("lk_m1", 32'h0000_00B1);
        drop_req(1);
        finish_ack("lk_m1");

        // Reset during BUSY: transaction abandoned, re-granted after release
        drive_req(1, 1'b1, 32'h0000_0300, 32'hBEEF_0001, 4'hC, 1'b0);
        step();
        check_req("rstb_pre");
        rst = 1'b0;
        #1;
        chk("rstb_bus_en", 64'(bif.o_bus_en), 64'd0);
        chk("rstb_wr_en",  64'(bif.o_wr_en), 64'd0);
        chk("rstb_addr",   64'(bif.o_addr), 64'd0);
        chk("rstb_wdata",  64'(bif.o_wr_data), 64'd0);
        chk("rstb_be",     64'(bif.o_byte_en), 64'd0);
        chk("rstb_grant",  64'(bif.o_grant), 64'd0);
        bif.i_ack = 1'b1;
        #1;
        chk("rstb_no_ack", 64'(bif.o_m_ack), 64'd0);
        step();
        chk("rstb_held", 64'(bif.o_bus_en), 64'd0);
        bif.i_ack = 1'b0;
        rst = 1'b1;
        step();
        check_req("rstb_post");
        do_ack("rstb", 32'h0000_00C1);
        drop_req(1);
        finish_ack("rstb");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
